// File: rtl/adder_arbiter_pkg.sv
// Shared constants, FSM encoding and operand bundle for the two-port adder arbiter.
// No logic; imported by the arbiter and the adder.
package adder_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sel;
  } op_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared 8-bit add/subtract unit: A two's complement, B sign-magnitude, 9-bit result.
// Latency: combinational; backpressure: none.
module adder_arbiter_adder
  import adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              sel_in,
  output logic [RES_W-1:0]  rez_out
);

  logic [DATA_W-1:0] c;
  logic [RES_W-1:0]  a_ext;
  logic [RES_W-1:0]  c_ext;

  always_comb begin
    // Negative sign-magnitude B becomes its two's complement; 0x80 folds to zero.
    c = b_in;
    if (b_in[DATA_W-1]) begin
      c = {1'b1, ~b_in[DATA_W-2:0]} + 8'd1;
    end
    a_ext   = {a_in[DATA_W-1], a_in};
    c_ext   = {c[DATA_W-1], c};
    rez_out = sel_in ? (a_ext - c_ext) : (a_ext + c_ext);
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between two level requesters; Done strobes per requester.
// Latency: grant edge N -> Rez_out/Done valid after edge N+2; backpressure: none, one op per 3 cycles.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter logic PRIO_INIT = REQ0
) (
  input  logic              Clk_in,
  input  logic              Rst_in,
  input  logic              Req0_in,
  input  logic [DATA_W-1:0] A0_in,
  input  logic [DATA_W-1:0] B0_in,
  input  logic              Sel0_in,
  input  logic              Req1_in,
  input  logic [DATA_W-1:0] A1_in,
  input  logic [DATA_W-1:0] B1_in,
  input  logic              Sel1_in,
  output logic              Done0_out,
  output logic              Done1_out,
  output logic              Grant_out,
  output logic              Busy_out,
  output logic [RES_W-1:0]  Rez_out
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  op_t              op_q, op_d;
  logic [RES_W-1:0] rez_q, rez_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [RES_W-1:0] adder_rez;
  logic             pick;

  adder_arbiter_adder u_adder (
    .a_in    (op_q.a),
    .b_in    (op_q.b),
    .sel_in  (op_q.sel),
    .rez_out (adder_rez)
  );

  always_comb begin
    pick = REQ0;
    if (Req0_in && Req1_in) begin
      pick = prio_q;
    end else if (Req1_in) begin
      pick = REQ1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    op_d    = op_q;
    rez_d   = rez_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req0_in || Req1_in) begin
          grant_d = pick;
          op_d    = (pick == REQ1) ? '{a: A1_in, b: B1_in, sel: Sel1_in}
                                   : '{a: A0_in, b: B0_in, sel: Sel0_in};
          state_d = CALC;
        end
      end
      CALC: begin
        rez_d   = adder_rez;
        state_d = DONE;
      end
      DONE: begin
        // Strobe is registered so it lands in the cycle after the DONE edge.
        done0_d = (grant_q == REQ0);
        done1_d = (grant_q == REQ1);
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= IDLE;
      grant_q <= REQ0;
      prio_q  <= PRIO_INIT;
      op_q    <= '0;
      rez_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      rez_q   <= rez_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign Done0_out = done0_q;
  assign Done1_out = done1_q;
  assign Grant_out = grant_q;
  assign Busy_out  = (state_q != IDLE);
  assign Rez_out   = rez_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter with a transaction-level reference and scoreboard.
module tb_adder_arbiter;

  logic       Clk_in, Rst_in;
  logic       Req0_in, Sel0_in, Req1_in, Sel1_in;
  logic [7:0] A0_in, B0_in, A1_in, B1_in;
  logic       Done0_out, Done1_out, Grant_out, Busy_out;
  logic [8:0] Rez_out;

  adder_arbiter #(.PRIO_INIT(1'b0)) dut (
    .Clk_in(Clk_in), .Rst_in(Rst_in),
    .Req0_in(Req0_in), .A0_in(A0_in), .B0_in(B0_in), .Sel0_in(Sel0_in),
    .Req1_in(Req1_in), .A1_in(A1_in), .B1_in(B1_in), .Sel1_in(Sel1_in),
    .Done0_out(Done0_out), .Done1_out(Done1_out), .Grant_out(Grant_out),
    .Busy_out(Busy_out), .Rez_out(Rez_out)
  );

  initial begin
    Clk_in = 1'b0;
    forever #5 Clk_in = ~Clk_in;
  end

  typedef struct {
    logic       idx;
    logic [8:0] rez;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_free = 0;
  logic ptr = 1'b0;
  logic cur_grant = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference arithmetic on signed integer values of the operands.
  function automatic logic [8:0] ref_rez(input logic [7:0] a, input logic [7:0] b, input logic sel);
    int av, cv, r;
    av = $signed(a);
    cv = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    r  = sel ? (av - cv) : (av + cv);
    return r[8:0];
  endfunction

  // Transaction model: a free server accepts one request, result is due three edges later.
  always @(posedge Clk_in) begin
    exp_t e;
    logic w;
    if (Rst_in) begin
      exp_q.delete();
      ptr       = 1'b0;
      next_free = 0;
    end else if (cyc >= next_free && (Req0_in || Req1_in)) begin
      w = (Req0_in && Req1_in) ? ptr : Req1_in;
      e.idx = w;
      e.rez = w ? ref_rez(A1_in, B1_in, Sel1_in) : ref_rez(A0_in, B0_in, Sel0_in);
      e.due = cyc + 3;
      exp_q.push_back(e);
      cur_grant = w;
      ptr       = ~w;
      next_free = cyc + 3;
    end
    cyc++;
  end

  always @(negedge Clk_in) begin
    exp_t e;
    if (mon_en) begin
      if (Done0_out && Done1_out) chk("both_done", 1, 0);
      if (Done0_out || Done1_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_who", Done1_out, e.idx);
          chk("sb_rez", Rez_out, e.rez);
          chk("sb_latency", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_done", 0, 1);
      end
      chk("busy", Busy_out, (cyc < next_free));
      if (Busy_out) chk("grant", Grant_out, cur_grant);
    end
  end

  task automatic wait_done(output logic got, output logic which, output int n);
    got = 1'b0; which = 1'b0; n = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge Clk_in);
      if (Done0_out || Done1_out) begin
        got = 1'b1; which = Done1_out; n = i;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    Req0_in = 1'b0; Req1_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk_in);
      if (!Busy_out && !Done0_out && !Done1_out) break;
    end
  endtask

  task automatic run_one(input string name, input logic idx, input logic [7:0] a,
                         input logic [7:0] b, input logic sel, input logic [8:0] req);
    logic got, which;
    int   n;
    wait_idle();
    if (idx) begin
      Req1_in = 1'b1; A1_in = a; B1_in = b; Sel1_in = sel;
    end else begin
      Req0_in = 1'b1; A0_in = a; B0_in = b; Sel0_in = sel;
    end
    @(negedge Clk_in);
    Req0_in = 1'b0; Req1_in = 1'b0;
    wait_done(got, which, n);
    if (got) begin
      chk({name, "_who"}, which, idx);
      chk({name, "_rez"}, Rez_out, req);
      chk({name, "_lat"}, n, 2);
    end
  endtask

  initial begin
    logic got, which;
    int   n;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, which;
    int   n;
    Rst_in = 1'b1; Req0_in = 1'b0; Req1_in = 1'b0;
    A0_in = '0; B0_in = '0; Sel0_in = 1'b0;
    A1_in = '0; B1_in = '0; Sel1_in = 1'b0;
    @(negedge Clk_in);
    @(negedge Clk_in);
    chk("rst_done0", Done0_out, 0);
    chk("rst_done1", Done1_out, 0);
    chk("rst_busy", Busy_out, 0);
    chk("rst_grant", Grant_out, 0);
    chk("rst_rez", Rez_out, 0);
    Rst_in = 1'b0;
    mon_en = 1'b1;
    repeat (5) begin
      @(negedge Clk_in);
      chk("idle_no_done", {Done0_out, Done1_out}, 0);
    end

    run_one("single", 1'b0, 8'h05, 8'h03, 1'b0, 9'h008);

    // Contention from reset: both held, service must alternate starting at 0.
    Rst_in = 1'b1;
    @(negedge Clk_in);
    Rst_in = 1'b0;
    Req0_in = 1'b1; A0_in = 8'h02; B0_in = 8'h01; Sel0_in = 1'b1;
    Req1_in = 1'b1; A1_in = 8'h10; B1_in = 8'h85; Sel1_in = 1'b1;
    wait_done(got, which, n);
    chk("cont1_who", which, 0);
    chk("cont1_rez", Rez_out, 9'h001);
    wait_done(got, which, n);
    chk("cont2_who", which, 1);
    chk("cont2_rez", Rez_out, 9'h015);
    wait_done(got, which, n);
    chk("cont3_who", which, 0);
    wait_done(got, which, n);
    chk("cont4_who", which, 1);

    run_one("max_add", 1'b1, 8'h7F, 8'h7F, 1'b0, 9'h0FE);
    run_one("min_sub", 1'b0, 8'h80, 8'h01, 1'b1, 9'h17F);
    run_one("neg_zero", 1'b1, 8'h03, 8'h80, 1'b0, 9'h003);

    // Operands and request change after the grant edge.
    wait_idle();
    Req0_in = 1'b1; A0_in = 8'h10; B0_in = 8'h01; Sel0_in = 1'b0;
    @(negedge Clk_in);
    A0_in = 8'hFF; Req0_in = 1'b0;
    wait_done(got, which, n);
    chk("latched_who", which, 0);
    chk("latched_rez", Rez_out, 9'h011);

    // Reset while in CALC aborts the operation.
    wait_idle();
    Req1_in = 1'b1; A1_in = 8'h20; B1_in = 8'h02; Sel1_in = 1'b0;
    @(negedge Clk_in);
    Req1_in = 1'b0; Rst_in = 1'b1;
    @(negedge Clk_in);
    Rst_in = 1'b0;
    chk("abort_rez", Rez_out, 0);
    chk("abort_busy", Busy_out, 0);
    repeat (5) begin
      @(negedge Clk_in);
      chk("abort_no_done", {Done0_out, Done1_out}, 0);
    end
    run_one("after_abort", 1'b0, 8'hF0, 8'h8A, 1'b1, 9'h1FA);

    for (int i = 0; i < 400; i++) begin
      @(negedge Clk_in);
      Req0_in = ($urandom_range(0, 3) != 0);
      Req1_in = ($urandom_range(0, 3) != 0);
      A0_in = 8'($urandom); B0_in = 8'($urandom); Sel0_in = 1'($urandom);
      A1_in = 8'($urandom); B1_in = 8'($urandom); Sel1_in = 1'($urandom);
      Rst_in = ($urandom_range(0, 63) == 0);
    end
    Rst_in = 1'b0; Req0_in = 1'b0; Req1_in = 1'b0;
    repeat (8) @(negedge Clk_in);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one instance of the team's 8-bit add/subtract unit between two requesters.
- Each requester raises a level request with operands A, B (sign-magnitude) and Sel.
- The arbiter grants round-robin, latches the granted operands, and registers the 9-bit result.
- It then pulses a per-requester done strobe.
- It sits between two client blocks and the combinational adder, so the adder's inputs are stable registered values.

Parameters:
- DATA_W, 8: operand width; fixed to 8 to match the shared adder.
- RES_W, DATA_W+1 = 9: result width (derived, not overridable).
- PRIO_INIT, 0: requester that wins the first simultaneous request after reset.

Ports:
- Clk_in  input  1  clock; all state changes on the rising edge.
- Rst_in  input  1  synchronous, active-high reset.
- Req0_in  input  1  requester 0 request (level).
- A0_in  input  8  requester 0 operand A (two's complement).
- B0_in  input  8  requester 0 operand B (sign-magnitude).
- Sel0_in  input  1  requester 0 op: 0 = add, 1 = subtract.
- Req1_in, A1_in, B1_in, Sel1_in  input  1/8/8/1  same as above, for requester 1.
- Done0_out  output  1  one-cycle strobe: Rez_out is valid for requester 0.
- Done1_out  output  1  one-cycle strobe: Rez_out is valid for requester 1.
- Grant_out  output  1  index of the requester currently being served; valid when Busy_out = 1.
- Busy_out  output  1  high in CALC and DONE.
- Rez_out  output  9  registered result; holds the last result until the next capture.

Behaviour:
- Reset (Rst_in = 1 at an edge):
  - state = IDLE; Done0/1 = 0; Busy = 0; Grant = 0; Rez_out = 0.
  - Priority pointer = PRIO_INIT.
  - Operand registers = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If exactly one Req is high, grant it.
  - If both are high, grant the requester named by the priority pointer.
  - On the grant edge: latch that requester's A, B, Sel into registers; set Grant; go to CALC.
  - If no Req is high, stay in IDLE.
- CALC:
  - The adder sees only the latched registers.
  - At the edge: Rez_out <= adder result; go to DONE.
- DONE:
  - Done[Grant] = 1 for exactly this cycle; the other Done stays 0.
  - Priority pointer <= ~Grant.
  - Next state is IDLE.
- Latency: Req sampled high in IDLE at edge N gives Rez_out valid and Done high during the cycle after edge N+2.
- Throughput: one operation per 3 cycles.
- Request handling:
  - Req is level-sensitive. A requester that keeps Req high after Done is served again.
  - With both requesting continuously, service alternates 0,1,0,1...
- Operands only need to be stable at the IDLE grant edge. Changes during CALC/DONE have no effect.
- Req dropped during CALC: the operation still completes and Done still pulses.
- Arithmetic (performed by the shared adder, restated for checking):
  - C = B if B[7] = 0.
  - C = ({1, ~B[6:0]} + 1) mod 256 if B[7] = 1.
  - Rez = sext9(A) + sext9(C) when Sel = 0; sext9(A) − sext9(C) when Sel = 1; mod 512.
  - No overflow flag; 9 bits cover the full range.
- Boundary cases:
  - B = 0x80 (negative zero) gives C = 0.
  - Reset asserted in CALC or DONE: abort immediately with no Done pulse. Rez_out = 0 and the pointer is reset.
  - Rst_in wins over every other event in the same cycle.

Decomposition:
- Shared package holds:
  - DATA_W and RES_W constants.
  - FSM state encoding: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Requester index constants REQ0 = 1'b0, REQ1 = 1'b1.
- One sub-module: the existing adder, instantiated unchanged as u_adder with operand/Sel registers on its inputs.
- Arbitration and the FSM stay in adder_arbiter; no further split.

Test Plan:
- Reset: hold Rst_in 2 cycles -> all outputs 0, Busy_out = 0; no Done while Req = 0 for 5 cycles.
- Single request: Req0 = 1, A0 = 0x05, B0 = 0x03, Sel0 = 0 -> Done0 pulses 1 cycle, 3 cycles after the sample edge; Rez_out = 0x008; Done1 stays 0.
- Contention: from reset, Req0 and Req1 both high and held:
  - Requester 0: A0 = 0x02, B0 = 0x01, Sel0 = 1 -> Done0 first with Rez_out = 0x001.
  - Requester 1: A1 = 0x10, B1 = 0x85, Sel1 = 1 -> Done1 next with Rez_out = 0x015.
  - Grants then continue to alternate.
- Range/sign: A = 0x7F, B = 0x7F, Sel = 0 -> 0x0FE. A = 0x80, B = 0x01, Sel = 1 -> 0x17F (−129). A = 0x03, B = 0x80, Sel = 0 -> 0x003.
- Operand change: after the grant edge, change A0 to 0xFF during CALC -> Rez_out reflects the latched value. Drop Req0 in CALC -> Done0 still pulses.
- Reset mid-operation: assert Rst_in in CALC -> no Done, Rez_out = 0. The next request is served normally with the nominal latency.
